// File: rtl/dds_sweep_ctrl.sv
// Linear tuning-word sweep generator feeding the DDS tuning input, configured over a byte port.
// Define SWEEP_TRIANGLE_EN for an up/down triangle sweep; the default build is a sawtooth.
module dds_sweep_ctrl #(
    parameter int unsigned TW_W    = 14,
    parameter int unsigned DWELL_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic            run,
    output logic [TW_W-1:0] tw_out,
    output logic            sweeping,
    output logic            sweep_done
);

    localparam int unsigned SUM_W = TW_W + 1;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [TW_W-1:0]    start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [TW_W-1:0]    tw_q, tw_nxt;
    logic [DWELL_W-1:0] cnt_q, cnt_nxt;
    logic               dir_q, dir_nxt;
    logic               done_q, done_nxt;
    logic               sweeping_q;
    logic [SUM_W-1:0]   sum_c, diff_c;

    // Config registers; writes only land while idle so a running sweep stays coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
        end else if (cfg_we && state == IDLE) begin
            case (cfg_addr)
                3'd0: start_q <= {start_q[TW_W-1:8], cfg_data};
                3'd1: start_q <= TW_W'({cfg_data, start_q[7:0]});
                3'd2: stop_q  <= {stop_q[TW_W-1:8], cfg_data};
                3'd3: stop_q  <= TW_W'({cfg_data, stop_q[7:0]});
                3'd4: step_q  <= {step_q[TW_W-1:8], cfg_data};
                3'd5: step_q  <= TW_W'({cfg_data, step_q[7:0]});
                3'd6: dwell_q <= {dwell_q[DWELL_W-1:8], cfg_data};
                3'd7: dwell_q <= DWELL_W'({cfg_data, dwell_q[7:0]});
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tw_q       <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            done_q     <= 1'b0;
            sweeping_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            tw_q       <= tw_nxt;
            cnt_q      <= cnt_nxt;
            dir_q      <= dir_nxt;
            done_q     <= done_nxt;
            sweeping_q <= (state_nxt != IDLE);
        end
    end

    // Next-state and step arithmetic; the extra sum bit catches overflow and borrow.
    always_comb begin
        state_nxt = state;
        tw_nxt    = tw_q;
        cnt_nxt   = cnt_q;
        dir_nxt   = dir_q;
        done_nxt  = 1'b0;
        sum_c     = SUM_W'(tw_q) + SUM_W'(step_q);
        diff_c    = SUM_W'(tw_q) - SUM_W'(step_q);

        case (state)
            IDLE: begin
                tw_nxt  = start_q;
                cnt_nxt = dwell_q;
                dir_nxt = DIR_UP;
                if (run) state_nxt = HOLD;
            end
            HOLD: begin
                if (!run)                state_nxt = IDLE;
                else if (cnt_q == '0)    state_nxt = STEP;
                else                     cnt_nxt   = cnt_q - DWELL_W'(1);
            end
            STEP: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = dwell_q;
                    if (step_q == '0 || start_q >= stop_q) begin
                        tw_nxt = start_q;
                    end else if (dir_q == DIR_DOWN) begin
                        if (diff_c[TW_W] || diff_c <= SUM_W'(start_q)) begin
                            tw_nxt   = start_q;
                            done_nxt = 1'b1;
                            dir_nxt  = DIR_UP;
                        end else begin
                            tw_nxt = diff_c[TW_W-1:0];
                        end
                    end else if (tw_q >= stop_q) begin
                        // Already parked at stop: sawtooth wrap back to start.
                        tw_nxt = start_q;
                    end else if (sum_c >= SUM_W'(stop_q)) begin
                        tw_nxt   = stop_q;
                        done_nxt = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
                        dir_nxt  = DIR_DOWN;
`else
                        dir_nxt  = DIR_UP;
`endif
                    end else begin
                        tw_nxt = sum_c[TW_W-1:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tw_out     = tw_q;
    assign sweeping   = sweeping_q;
    assign sweep_done = done_q;

endmodule
